// File: rtl/gpio_int_detect.sv
// GPIO input conditioning: two-flop synchroniser, optional prescaled glitch filter per bit,
// and per-bit edge interrupt latching with mask and clear.
module gpio_int_detect #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned PRESCALE = 8,
   parameter int unsigned FILT_LEN = 3
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] PortIn,
   input  logic [WIDTH-1:0] FiltEn,
   input  logic [WIDTH-1:0] IntMask,
   input  logic [WIDTH-1:0] IntEdge,
   input  logic [WIDTH-1:0] IntReset,
   output logic [WIDTH-1:0] PortFilt,
   output logic [WIDTH-1:0] IntFilt,
   output logic             IntStatus
);

   localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned CntW = $clog2(FILT_LEN) + 1;
   localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);
   localparam logic [CntW-1:0] CntMax = CntW'(FILT_LEN - 1);

   logic [WIDTH-1:0] sync1Q, sync2Q;
   logic [WIDTH-1:0] portFiltQ, portFiltD;
   logic [WIDTH-1:0] prevFiltQ;
   logic [WIDTH-1:0] intFiltQ, intFiltD;
   logic [WIDTH-1:0] intEvent;
   logic [PreW-1:0]  preCntQ, preCntD;
   logic             tick;
   logic [CntW-1:0]  cntQ [WIDTH];
   logic [CntW-1:0]  cntD [WIDTH];

   // With PRESCALE=1 PreMax is 0, so the counter sits at 0 and tick is constant high.
   always_comb begin
      tick    = (preCntQ == PreMax);
      preCntD = tick ? '0 : preCntQ + PreW'(1);
   end

   always_comb begin
      portFiltD = portFiltQ;
      cntD      = cntQ;
      for (int i = 0; i < WIDTH; i++) begin
         if (!FiltEn[i]) begin
            portFiltD[i] = sync2Q[i];
            cntD[i]      = '0;
         end else if (tick) begin
            if (sync2Q[i] == portFiltQ[i]) begin
               cntD[i] = '0;
            end else if (cntQ[i] == CntMax) begin
               portFiltD[i] = sync2Q[i];
               cntD[i]      = '0;
            end else begin
               cntD[i] = cntQ[i] + CntW'(1);
            end
         end
      end
   end

   // Events come only from filtered-level transitions, so flipping IntEdge alone is silent.
   always_comb begin
      intEvent = (~IntEdge & portFiltQ & ~prevFiltQ) | (IntEdge & ~portFiltQ & prevFiltQ);
      intFiltD = IntMask & (intEvent | (intFiltQ & ~IntReset));
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync1Q    <= '0;
         sync2Q    <= '0;
         portFiltQ <= '0;
         prevFiltQ <= '0;
         intFiltQ  <= '0;
         preCntQ   <= '0;
         cntQ      <= '{default: '0};
      end else begin
         sync1Q    <= PortIn;
         sync2Q    <= sync1Q;
         portFiltQ <= portFiltD;
         prevFiltQ <= portFiltQ;
         intFiltQ  <= intFiltD;
         preCntQ   <= preCntD;
         cntQ      <= cntD;
      end
   end

   assign PortFilt  = portFiltQ;
   assign IntFilt   = intFiltQ;
   assign IntStatus = |intFiltQ;

endmodule

// File: tb/tb_gpio_int_detect.sv
// Scoreboard bench for gpio_int_detect: expectations are queued with the cycle they are due
// and compared on the falling edge when that cycle arrives.
module tb_gpio_int_detect;

   localparam int WIDTH    = 16;
   localparam int PRESCALE = 4;
   localparam int FILT_LEN = 3;
   localparam int KPort    = 0;
   localparam int KInt     = 1;
   localparam int KStat    = 2;

   typedef struct {
      string            tag;
      int               cyc;
      int               kind;
      logic [WIDTH-1:0] val;
   } ExpEntry;

   logic             Clk = 1'b0;
   logic             Reset;
   logic [WIDTH-1:0] PortIn, FiltEn, IntMask, IntEdge, IntReset;
   logic [WIDTH-1:0] PortFilt, IntFilt;
   logic             IntStatus;

   int      checks = 0;
   int      errors = 0;
   int      cyc;
   ExpEntry expQ[$];

   gpio_int_detect #(
      .WIDTH   (WIDTH),
      .PRESCALE(PRESCALE),
      .FILT_LEN(FILT_LEN)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .PortIn   (PortIn),
      .FiltEn   (FiltEn),
      .IntMask  (IntMask),
      .IntEdge  (IntEdge),
      .IntReset (IntReset),
      .PortFilt (PortFilt),
      .IntFilt  (IntFilt),
      .IntStatus(IntStatus)
   );

   always #5 Clk = ~Clk;

   // cyc = number of rising edges since Reset was released
   always @(posedge Clk or posedge Reset) begin
      if (Reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic checkVal(input string tag, input logic [WIDTH-1:0] obs,
                           input logic [WIDTH-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %h, expected %h (cycle %0d, t=%0t)",
                  tag, obs, exp, cyc, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] sample(input int kind);
      case (kind)
         KPort:   return PortFilt;
         KInt:    return IntFilt;
         default: return {{(WIDTH-1){1'b0}}, IntStatus};
      endcase
   endfunction

   always @(negedge Clk) begin
      if (!Reset) begin
         for (int i = expQ.size() - 1; i >= 0; i--) begin
            if (expQ[i].cyc == cyc) begin
               checkVal(expQ[i].tag, sample(expQ[i].kind), expQ[i].val);
               expQ.delete(i);
            end
         end
      end
   end

   task automatic expectAt(input string tag, input int kind, input int at,
                           input logic [WIDTH-1:0] val);
      ExpEntry e;
      e.tag  = tag;
      e.cyc  = at;
      e.kind = kind;
      e.val  = val;
      expQ.push_back(e);
   endtask

   task automatic expectSpan(input string tag, input int kind, input int from, input int to,
                             input logic [WIDTH-1:0] val);
      for (int c = from; c <= to; c++) expectAt(tag, kind, c, val);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic pulseClear(input string tag, input logic [WIDTH-1:0] mask,
                             input logic [WIDTH-1:0] expIf);
      int n;
      n = cyc;
      IntReset = mask;
      expectAt({tag, "_if"}, KInt, n + 1, expIf);
      expectAt({tag, "_st"}, KStat, n + 1, {{(WIDTH-1){1'b0}}, |expIf});
      step(1);
      IntReset = '0;
   endtask

   // First rising edge >= e at which the prescaler tick is sampled.
   function automatic int nextTick(input int e);
      int k;
      k = e;
      while (k % PRESCALE != 0) k++;
      return k;
   endfunction

   initial begin
      int n, t;
      Reset    = 1'b1;
      PortIn   = '0;
      FiltEn   = '0;
      IntMask  = '0;
      IntEdge  = '0;
      IntReset = '0;
      #23;
      checkVal("rst_pf", PortFilt, 16'h0000);
      checkVal("rst_if", IntFilt, 16'h0000);
      checkVal("rst_st", {15'h0, IntStatus}, 16'h0000);

      // Pads high through reset: release yields a rising event, latched only where masked.
      PortIn  = 16'h0003;
      IntMask = 16'h0001;
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      expectAt("rel_pf2", KPort, 2, 16'h0000);
      expectAt("rel_pf3", KPort, 3, 16'h0003);
      expectAt("rel_if3", KInt, 3, 16'h0000);
      expectAt("rel_if4", KInt, 4, 16'h0001);
      expectAt("rel_st4", KStat, 4, 16'h0001);
      expectSpan("rel_hold", KInt, 5, 8, 16'h0001);
      step(8);
      pulseClear("rel_clr", 16'h0001, 16'h0000);
      n = cyc;
      PortIn = 16'h0000;
      expectAt("fall_pf", KPort, n + 3, 16'h0000);
      expectSpan("fall_noint", KInt, n + 1, n + 5, 16'h0000);
      step(6);

      // Bypass rising edge
      n = cyc;
      PortIn = 16'h0001;
      expectAt("byp_pf2", KPort, n + 2, 16'h0000);
      expectAt("byp_pf3", KPort, n + 3, 16'h0001);
      expectAt("byp_if3", KInt, n + 3, 16'h0000);
      expectAt("byp_if4", KInt, n + 4, 16'h0001);
      expectAt("byp_st4", KStat, n + 4, 16'h0001);
      step(6);
      pulseClear("byp_clr", 16'h0001, 16'h0000);
      PortIn = 16'h0000;
      step(6);

      // Glitch of 6 cycles on a filtered bit is rejected
      FiltEn = 16'h0001;
      n = cyc;
      PortIn = 16'h0001;
      expectSpan("glitch_pf", KPort, n + 1, n + 16, 16'h0000);
      expectSpan("glitch_if", KInt, n + 1, n + 16, 16'h0000);
      step(6);
      PortIn = 16'h0000;
      step(10);

      // Held level accepted on the FILT_LEN-th differing tick
      n = cyc;
      PortIn = 16'h0001;
      t = nextTick(n + 3) + (FILT_LEN - 1) * PRESCALE;
      expectSpan("filt_pf_wait", KPort, n + 1, t - 1, 16'h0000);
      expectAt("filt_pf", KPort, t, 16'h0001);
      expectAt("filt_if_pre", KInt, t, 16'h0000);
      expectAt("filt_if", KInt, t + 1, 16'h0001);
      expectAt("filt_st", KStat, t + 1, 16'h0001);
      step(t + 2 - n);
      pulseClear("filt_clr", 16'h0001, 16'h0000);
      FiltEn = 16'h0000;
      n = cyc;
      PortIn = 16'h0000;
      expectAt("filt_off_pf", KPort, n + 3, 16'h0000);
      step(4);

      // Falling-edge interrupt on bit 8
      IntEdge = 16'h0100;
      IntMask = 16'h0100;
      n = cyc;
      PortIn = 16'h0100;
      expectSpan("fe_rise0", KInt, n + 1, n + 6, 16'h0000);
      step(6);
      n = cyc;
      PortIn = 16'h0000;
      expectAt("fe_pf", KPort, n + 3, 16'h0000);
      expectAt("fe_if3", KInt, n + 3, 16'h0000);
      expectAt("fe_if4", KInt, n + 4, 16'h0100);
      expectAt("fe_st4", KStat, n + 4, 16'h0001);
      step(6);
      n = cyc;
      PortIn = 16'h0100;
      expectSpan("fe_rise_hold", KInt, n + 1, n + 6, 16'h0100);
      step(6);
      pulseClear("fe_clr", 16'h0100, 16'h0000);
      n = cyc;
      PortIn = 16'h0000;
      expectAt("fe_if_again", KInt, n + 4, 16'h0100);
      step(6);

      // Mask clears pending and drops events while low
      n = cyc;
      IntMask = 16'h0000;
      expectAt("mask_clr", KInt, n + 1, 16'h0000);
      expectAt("mask_st", KStat, n + 1, 16'h0000);
      step(1);
      n = cyc;
      PortIn = 16'h0100;
      expectSpan("mask_drop", KInt, n + 1, n + 18, 16'h0000);
      step(6);
      PortIn = 16'h0000;
      step(6);
      IntMask = 16'h0100;
      step(6);

      // Edge-select changes alone create no event
      n = cyc;
      IntEdge = 16'h0000;
      expectSpan("edge_sw_lo", KInt, n + 1, n + 4, 16'h0000);
      step(4);
      n = cyc;
      IntEdge = 16'h0100;
      PortIn  = 16'h0100;
      expectSpan("edge_sw_hi", KInt, n + 1, n + 10, 16'h0000);
      step(5);
      IntEdge = 16'h0000;
      step(5);

      // Clear and set in the same cycle: set wins
      IntMask = 16'h0008;
      n = cyc;
      PortIn = 16'h0008;
      expectAt("col_set", KInt, n + 4, 16'h0008);
      step(6);
      PortIn = 16'h0000;
      step(5);
      n = cyc;
      PortIn = 16'h0008;
      step(3);
      IntReset = 16'h0008;
      expectAt("col_keep", KInt, n + 4, 16'h0008);
      expectAt("col_keep2", KInt, n + 5, 16'h0008);
      step(1);
      IntReset = 16'h0000;
      step(1);
      pulseClear("col_clr", 16'h0008, 16'h0000);

      // Asynchronous reset with pending interrupts and a filter mid-count
      PortIn = 16'h0000;
      step(4);
      IntMask = 16'hFFFF;
      FiltEn  = 16'h0200;
      n = cyc;
      PortIn = 16'h02FF;
      expectAt("pre_rst_pf", KPort, n + 3, 16'h00FF);
      expectAt("pre_rst_if", KInt, n + 4, 16'h00FF);
      step(nextTick(n + 3) + 1 - n);
      #3;
      Reset = 1'b1;
      #1;
      checkVal("arst_pf", PortFilt, 16'h0000);
      checkVal("arst_if", IntFilt, 16'h0000);
      checkVal("arst_st", {15'h0, IntStatus}, 16'h0000);
      checkVal("pre_rst_queue", WIDTH'(expQ.size()), 16'h0000);
      expQ.delete();
      PortIn = 16'h0000;
      step(2);
      Reset = 1'b0;
      expectSpan("post_rst_pf", KPort, 1, 20, 16'h0000);
      expectSpan("post_rst_if", KInt, 1, 20, 16'h0000);
      expectSpan("post_rst_st", KStat, 1, 20, 16'h0000);
      step(22);

      checkVal("queue_empty", WIDTH'(expQ.size()), 16'h0000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpio_int_detect.md
GPIO_INT_DETECT -- requirements
Module: gpio_int_detect

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- WIDTH, 16, number of port bits
- PRESCALE, 8, clock cycles per filter sample tick (>=1)
- FILT_LEN, 3, consecutive differing ticks needed to accept a new level (>=1)

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- Clk, in, 1, single clock; all state on rising edge
- Reset, in, 1, asynchronous, active-high reset
- PortIn, in, WIDTH, raw pad levels (asynchronous to Clk)
- FiltEn, in, WIDTH, per-bit glitch filter enable (0 = bypass)
- IntMask, in, WIDTH, per-bit interrupt enable
- IntEdge, in, WIDTH, per-bit edge select (0 = rising, 1 = falling)
- IntReset, in, WIDTH, per-bit pending clear, one-cycle pulse
- PortFilt, out, WIDTH, synchronised and filtered port levels
- IntFilt, out, WIDTH, per-bit pending interrupt flags
- IntStatus, out, 1, OR of IntFilt

Function
REQ-003 Each PortIn bit SHALL pass through a two-flop synchroniser (Sync1, then Sync2); only Sync2 is used downstream.
REQ-004 The prescaler SHALL count 0..PRESCALE-1 and wrap, free-running from reset. Tick SHALL be high for one cycle when count = PRESCALE-1. With PRESCALE=1, Tick SHALL be high every cycle.
REQ-005 Filtered bit i (FiltEn[i]=1), per-bit counter Cnt[i] of width clog2(FILT_LEN)+1:
- No Tick: hold.
- Tick and Sync2[i] = PortFilt[i]: Cnt[i] <= 0.
- Tick and differ and Cnt[i] = FILT_LEN-1: PortFilt[i] <= Sync2[i], Cnt[i] <= 0.
- Tick and differ otherwise: Cnt[i] <= Cnt[i]+1.
REQ-006 Bypassed bit i (FiltEn[i]=0): PortFilt[i] <= Sync2[i] every cycle and Cnt[i] <= 0. Toggling FiltEn mid-count SHALL discard the partial count.
REQ-007 PrevFilt SHALL register PortFilt every cycle. Event[i] SHALL be PortFilt[i] & ~PrevFilt[i] when IntEdge[i]=0, and ~PortFilt[i] & PrevFilt[i] when IntEdge[i]=1.
REQ-008 Changing IntEdge SHALL NOT by itself create an event; only a PortFilt transition does.
REQ-009 Pending update each cycle: IntFilt[i] <= IntMask[i] & (Event[i] | (IntFilt[i] & ~IntReset[i])).
REQ-010 When Event[i] and IntReset[i] occur in the same cycle, the set SHALL win and IntFilt[i] SHALL be 1.
REQ-011 IntMask[i]=0 SHALL clear IntFilt[i] on the next edge, and events on that bit SHALL be dropped, not remembered.
REQ-012 IntStatus SHALL be a combinational OR of the IntFilt register bits only (glitch-free).
REQ-013 Bypass latency: PortIn stable before edge 1 -> PortFilt updates at edge 3 -> IntFilt/IntStatus set at edge 4.
REQ-014 Filtered latency: PortFilt SHALL update on the FILT_LEN-th consecutive Tick at which Sync2 differs from PortFilt. IntFilt SHALL follow one edge later.
REQ-015 A pulse on Sync2 that reverts before FILT_LEN ticks SHALL leave PortFilt unchanged and raise no interrupt.

Reset
REQ-016 Reset=1 SHALL asynchronously clear Sync1, Sync2, PortFilt, PrevFilt, all Cnt, the prescaler, and IntFilt. IntStatus SHALL be 0 while Reset is asserted.
REQ-017 After Reset is released, a pad held high SHALL produce a 0->1 PortFilt transition. This is a legal rising event and is latched only if IntMask is set.
REQ-018 Reset asserted mid-filter-count or with interrupts pending SHALL discard all state, with no residual event after release.

Verification (PRESCALE=4, FILT_LEN=3 unless noted)
REQ-019 Bypass rising edge:
- Setup: FiltEn=0, IntMask=0x0001, IntEdge=0.
- Stimulus: PortIn 0x0000 -> 0x0001 before edge 1.
- Required: PortFilt=0x0001 after edge 3; IntFilt=0x0001 and IntStatus=1 after edge 4.
REQ-020 Glitch rejection:
- Setup: FiltEn=0x0001.
- Stimulus: PortIn[0] high for 6 cycles (spans at most 2 ticks).
- Required: PortFilt and IntFilt stay 0x0000.
- Then: hold high for 12+ cycles -> PortFilt[0]=1 on the 3rd differing tick and IntFilt[0]=1 one cycle later.
REQ-021 Falling edge with mask:
- Setup: IntEdge=0x0100, IntMask=0x0100, FiltEn=0, bit 8 steady high.
- Stimulus: drive bit 8 low, then raise it again.
- Required: IntFilt=0x0100 after the fall only; the rise does not set it.
- Then: IntMask=0 -> IntFilt=0x0000 next edge.
REQ-022 Clear/set collision:
- Setup: IntFilt[3]=1.
- Stimulus: IntReset=0x0008 in the same cycle as a new Event[3].
- Required: IntFilt[3] stays 1.
- Then: IntReset alone -> IntFilt[3]=0 and IntStatus=0.
REQ-023 Asynchronous reset:
- Setup: IntFilt=0x00FF and Cnt mid-count.
- Stimulus: assert Reset between clock edges.
- Required: IntFilt, PortFilt and IntStatus are 0 immediately; no event occurs after release with PortIn=0.
